// File: rtl/pacman_sprite_drawer_if.sv
// Sprite position request channel: one position/facing per frame handed from
// the game logic (master) to the sprite drawer (slave) via valid/ready.
interface pacman_sprite_drawer_if;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       dir_left;
    logic       pos_valid;
    logic       pos_ready;

    modport master (
        output pos_x,
        output pos_y,
        output dir_left,
        output pos_valid,
        input  pos_ready
    );

    modport slave (
        input  pos_x,
        input  pos_y,
        input  dir_left,
        input  pos_valid,
        output pos_ready
    );
endinterface

// File: rtl/pacman_sprite_drawer.sv
// pacman_sprite_drawer: converts the VGA scan position into sprite ROM
// row/column addresses and composites the ROM color over the background,
// treating TRANSP as see-through. The pipeline is 3 clocks deep with no
// bubbles. A new sprite position is accepted once per frame and only becomes
// active at the first non-visible line, so the sprite never tears.
// Optional feature macro: SPRITE_MIRROR_EN (horizontal flip when facing left).
module pacman_sprite_drawer #(
    parameter int          SPRITE_W = 10,
    parameter int          SPRITE_H = 10,
    parameter int          V_ACTIVE = 480,
    parameter logic [9:0]  RESET_X  = 10'd0,
    parameter logic [9:0]  RESET_Y  = 10'd0,
    parameter logic [11:0] TRANSP   = 12'h000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    x,
    input  logic [9:0]                    y,
    input  logic                          video_on,
    input  logic [11:0]                   bg_rgb,
    pacman_sprite_drawer_if.slave         pos_if,
    output logic [3:0]                    rom_row,
    output logic [3:0]                    rom_col,
    input  logic [11:0]                   color_data,
    output logic [11:0]                   rgb_out
);

    localparam logic [0:0]  S_IDLE = 1'b0;
    localparam logic [0:0]  S_PEND = 1'b1;

    localparam logic [10:0] SPRITE_W_C = 11'(SPRITE_W);
    localparam logic [10:0] SPRITE_H_C = 11'(SPRITE_H);
    localparam logic [9:0]  V_ACTIVE_C = 10'(V_ACTIVE);
`ifdef SPRITE_MIRROR_EN
    localparam logic [3:0]  MIRROR_BASE_C = 4'(SPRITE_W - 1);
`endif

    // Position handshake and active/pending sprite position state.
    logic [0:0]  state_r;
    logic        pos_ready_r;
    logic [9:0]  pend_x_r;
    logic [9:0]  pend_y_r;
    logic        pend_left_r;
    logic [9:0]  act_x_r;
    logic [9:0]  act_y_r;
    logic        act_left_r;

    // Stage-0 combinational hit test results.
    logic [10:0] ax_s;
    logic [10:0] ay_s;
    logic [10:0] px_s;
    logic [10:0] py_s;
    logic [10:0] dx_s;
    logic [10:0] dy_s;
    logic        hit_s;
    logic        commit_pt_s;
    logic [3:0]  row_nxt_s;
    logic [3:0]  col_nxt_s;

    // Pipeline side-band registers.
    logic        hit1_r;
    logic        von1_r;
    logic [11:0] bg1_r;
    logic        hit2_r;
    logic        von2_r;
    logic [11:0] bg2_r;
    logic [3:0]  rom_row_r;
    logic [3:0]  rom_col_r;
    logic [11:0] rgb_out_r;

    // Upper difference bits never address the ROM; facing is unused without mirroring.
    logic        unused_bits_s;
    assign unused_bits_s = &{1'b0, dx_s[10:4], dy_s[10:4], act_left_r};

    assign commit_pt_s = (x == 10'd0) && (y == V_ACTIVE_C);

    // Position FSM: capture a request while idle, commit it at vblank start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            pos_ready_r <= 1'b1;
            pend_x_r    <= 10'd0;
            pend_y_r    <= 10'd0;
            pend_left_r <= 1'b0;
            act_x_r     <= RESET_X;
            act_y_r     <= RESET_Y;
            act_left_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pos_if.pos_valid) begin
                        pend_x_r    <= pos_if.pos_x;
                        pend_y_r    <= pos_if.pos_y;
                        pend_left_r <= pos_if.dir_left;
                        state_r     <= S_PEND;
                        pos_ready_r <= 1'b0;
                    end
                end
                S_PEND: begin
                    if (commit_pt_s) begin
                        act_x_r     <= pend_x_r;
                        act_y_r     <= pend_y_r;
                        act_left_r  <= pend_left_r;
                        state_r     <= S_IDLE;
                        pos_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    pos_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Stage 0: 11-bit hit test so a sprite near the right/bottom edge never wraps.
    always_comb begin
        ax_s  = {1'b0, act_x_r};
        ay_s  = {1'b0, act_y_r};
        px_s  = {1'b0, x};
        py_s  = {1'b0, y};
        dx_s  = px_s - ax_s;
        dy_s  = py_s - ay_s;
        hit_s = video_on
              && (px_s >= ax_s) && (px_s < (ax_s + SPRITE_W_C))
              && (py_s >= ay_s) && (py_s < (ay_s + SPRITE_H_C));
    end

    // Stage 0: ROM address selection, including the optional horizontal flip.
    always_comb begin
        row_nxt_s = 4'd0;
        col_nxt_s = 4'd0;
        if (hit_s) begin
            row_nxt_s = dy_s[3:0];
`ifdef SPRITE_MIRROR_EN
            if (act_left_r) begin
                col_nxt_s = MIRROR_BASE_C - dx_s[3:0];
            end else begin
                col_nxt_s = dx_s[3:0];
            end
`else
            col_nxt_s = dx_s[3:0];
`endif
        end else begin
            row_nxt_s = 4'd0;
            col_nxt_s = 4'd0;
        end
    end

    // Stage 1: register ROM address and delay hit/video_on/background alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_row_r <= 4'd0;
            rom_col_r <= 4'd0;
            hit1_r    <= 1'b0;
            von1_r    <= 1'b0;
            bg1_r     <= 12'h000;
        end else begin
            rom_row_r <= row_nxt_s;
            rom_col_r <= col_nxt_s;
            hit1_r    <= hit_s;
            von1_r    <= video_on;
            bg1_r     <= bg_rgb;
        end
    end

    // Stage 2: wait out the ROM's registered read so side-band meets color_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit2_r <= 1'b0;
            von2_r <= 1'b0;
            bg2_r  <= 12'h000;
        end else begin
            hit2_r <= hit1_r;
            von2_r <= von1_r;
            bg2_r  <= bg1_r;
        end
    end

    // Stage 3: blank outside the visible area, else sprite over background.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out_r <= 12'h000;
        end else if (!von2_r) begin
            rgb_out_r <= 12'h000;
        end else if (hit2_r && (color_data != TRANSP)) begin
            rgb_out_r <= color_data;
        end else begin
            rgb_out_r <= bg2_r;
        end
    end

    assign pos_if.pos_ready = pos_ready_r;
    assign rom_row          = rom_row_r;
    assign rom_col          = rom_col_r;
    assign rgb_out          = rgb_out_r;

endmodule
